// File: rtl/alu_op_sequencer.sv
// Opcode sequencer for the game CPU ALU: accepts an opcode over valid/ready and drives a
// registered one-hot op select; mul/div hold the unit busy for a configurable cycle count.
module alu_op_sequencer #(
  parameter int OPW        = 5,
  parameter int NUM_OPS    = 8,
  parameter int MUL_OP     = 6,
  parameter int DIV_OP     = 7,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_opcode,
  output logic [NUM_OPS-1:0] out_onehot,
  output logic               out_valid,
  output logic               out_illegal,
  output logic               busy,
  output logic               done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [OPW-1:0] MUL_CODE = OPW'(MUL_OP);
  localparam logic [OPW-1:0] DIV_CODE = OPW'(DIV_OP);
  localparam logic [CW-1:0]  MUL_LOAD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0]  DIV_LOAD = CW'(DIV_CYCLES - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_next_count;
  logic [NUM_OPS-1:0]   r_onehot;
  logic                 r_illegal;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_next_valid;
  logic                 w_next_done;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_is_multi;
  logic                 w_needs_wait;
  logic [CW-1:0]        w_load;
  logic [NUM_OPS-1:0]   w_onehot;

  assign in_ready = (r_state == IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  assign w_legal    = 32'(in_opcode) < NUM_OPS;
  assign w_is_mul   = w_legal && (in_opcode == MUL_CODE);
  assign w_is_div   = w_legal && (in_opcode == DIV_CODE);
  assign w_is_multi = w_is_mul || w_is_div;
  assign w_onehot   = w_legal ? (NUM_OPS'(1) << in_opcode) : '0;
  assign w_load     = w_is_mul ? MUL_LOAD : DIV_LOAD;

  // A 2-cycle op completes on the edge after accept, exactly like a single-cycle op,
  // so only longer ops enter MULTI.
  assign w_needs_wait = w_is_mul ? (MUL_CYCLES > 2) : (DIV_CYCLES > 2);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_valid = 1'b0;
    w_next_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_multi && w_needs_wait) begin
            w_next_state = MULTI;
            w_next_count = w_load;
          end else begin
            w_next_valid = 1'b1;
            w_next_done  = w_is_multi;
          end
        end
      end
      MULTI: begin
        // Counter holds N-2 on entry so completion lands N-1 cycles after the accept edge.
        w_next_count = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_next_state = IDLE;
          w_next_count = '0;
          w_next_valid = 1'b1;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_count = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_onehot  <= '0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_valid <= w_next_valid;
      r_done  <= w_next_done;
      r_busy  <= (w_next_state == MULTI);
      if (w_accept) begin
        r_onehot  <= w_onehot;
        r_illegal <= !w_legal;
      end
    end
  end

  assign out_onehot  = r_onehot;
  assign out_illegal = r_illegal;
  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a default instance and a small-parameter instance, each
// compared every cycle against a completion-time model, plus directed literal checks.
module tb_alu_op_sequencer;

  logic        clock;
  logic        rst [2];
  logic        vld [2];
  logic [5:0]  opc [2];

  logic        a_rdy, a_ov, a_oi, a_bsy, a_dn;
  logic [7:0]  a_oh;
  logic        b_rdy, b_ov, b_oi, b_bsy, b_dn;
  logic [15:0] b_oh;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  alu_op_sequencer u_a (
    .clock(clock), .reset(rst[0]), .in_valid(vld[0]), .in_ready(a_rdy),
    .in_opcode(opc[0][4:0]), .out_onehot(a_oh), .out_valid(a_ov),
    .out_illegal(a_oi), .busy(a_bsy), .done(a_dn)
  );

  alu_op_sequencer #(
    .OPW(6), .NUM_OPS(16), .MUL_OP(6), .DIV_OP(7), .MUL_CYCLES(2), .DIV_CYCLES(3)
  ) u_b (
    .clock(clock), .reset(rst[1]), .in_valid(vld[1]), .in_ready(b_rdy),
    .in_opcode(opc[1]), .out_onehot(b_oh), .out_valid(b_ov),
    .out_illegal(b_oi), .busy(b_bsy), .done(b_dn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: for each instance remember the selected op and the cycle index at which the
  // current op completes; busy/valid/done/ready all follow from that number.
  int          cyc = 0;
  int          m_done_at [2] = '{-1, -1};
  bit          m_multi   [2] = '{0, 0};
  bit          m_illegal [2] = '{0, 0};
  logic [15:0] m_onehot  [2] = '{16'h0, 16'h0};
  int          p_num [2] = '{8, 16};
  int          p_mul [2] = '{32, 2};
  int          p_div [2] = '{32, 3};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      int  op;
      int  n;
      bit  legal;
      op = (i == 0) ? int'(opc[0][4:0]) : int'(opc[1]);
      if (rst[i]) begin
        m_done_at[i] = -1;
        m_multi[i]   = 0;
        m_illegal[i] = 0;
        m_onehot[i]  = '0;
      end else if (vld[i] && !(m_done_at[i] > cyc)) begin
        legal        = op < p_num[i];
        m_onehot[i]  = legal ? (16'(1) << op) : 16'h0;
        m_illegal[i] = !legal;
        m_multi[i]   = legal && (op == 6 || op == 7);
        n = !m_multi[i] ? 2 : (op == 6 ? p_mul[i] : p_div[i]);
        m_done_at[i] = cyc + n - 1;
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        string nm;
        bit    e_valid, e_busy;
        nm      = (i == 0) ? "a_" : "b_";
        e_valid = (m_done_at[i] == cyc);
        e_busy  = (m_done_at[i] > cyc);
        check({nm, "valid"},   32'(i ? b_ov  : a_ov),  32'(e_valid));
        check({nm, "done"},    32'(i ? b_dn  : a_dn),  32'(e_valid && m_multi[i]));
        check({nm, "busy"},    32'(i ? b_bsy : a_bsy), 32'(e_busy));
        check({nm, "ready"},   32'(i ? b_rdy : a_rdy), 32'(!e_busy && !rst[i]));
        check({nm, "illegal"}, 32'(i ? b_oi  : a_oi),  32'(m_illegal[i]));
        check({nm, "onehot"},  32'(i ? b_oh  : {8'h0, a_oh}), 32'(m_onehot[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    int dn_count;
    rst[0] = 1'b1; rst[1] = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    opc[0] = '0;   opc[1] = '0;
    repeat (2) tick();
    check("rst_onehot",  32'(a_oh),  32'h0);
    check("rst_valid",   32'(a_ov),  32'h0);
    check("rst_illegal", 32'(a_oi),  32'h0);
    check("rst_busy",    32'(a_bsy), 32'h0);
    check("rst_done",    32'(a_dn),  32'h0);
    check("rst_ready",   32'(a_rdy), 32'h0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    cmp_en = 1;

    // Single-cycle sub, then idle cycle
    vld[0] = 1'b1; opc[0] = 6'd1;
    tick();
    check("sub_onehot", 32'(a_oh), 32'h02);
    check("sub_valid",  32'(a_ov), 32'h1);
    check("sub_busy",   32'(a_bsy), 32'h0);
    vld[0] = 1'b0;
    tick();
    check("sub_valid_drop", 32'(a_ov), 32'h0);
    check("sub_onehot_hold", 32'(a_oh), 32'h02);

    // Back-to-back add, and, sra
    vld[0] = 1'b1; opc[0] = 6'd0;
    tick();
    check("b2b_0_onehot", 32'(a_oh), 32'h01);
    check("b2b_0_ready",  32'(a_rdy), 32'h1);
    opc[0] = 6'd2;
    tick();
    check("b2b_2_onehot", 32'(a_oh), 32'h04);
    check("b2b_2_valid",  32'(a_ov), 32'h1);
    opc[0] = 6'd5;
    tick();
    check("b2b_5_onehot", 32'(a_oh), 32'h20);
    check("b2b_5_valid",  32'(a_ov), 32'h1);
    vld[0] = 1'b0;
    tick();

    // 32-cycle mul with an add held pending during busy
    vld[0] = 1'b1; opc[0] = 6'd6;
    tick();
    check("mul_busy",    32'(a_bsy), 32'h1);
    check("mul_ready",   32'(a_rdy), 32'h0);
    check("mul_onehot",  32'(a_oh),  32'h40);
    check("model_mul_done_at", 32'(m_done_at[0]), 32'(cyc + 30));
    opc[0] = 6'd0;
    k = 1;
    while (!a_dn && k < 100) begin
      tick();
      k++;
    end
    check("mul_done_latency", 32'(k), 32'd31);
    check("mul_done_valid",   32'(a_ov), 32'h1);
    check("mul_done_onehot",  32'(a_oh), 32'h40);
    check("mul_done_busy",    32'(a_bsy), 32'h0);
    tick();
    check("pending_add_onehot", 32'(a_oh), 32'h01);
    check("pending_add_done",   32'(a_dn), 32'h0);
    vld[0] = 1'b0;
    tick();

    // Illegal opcode, then a legal one clears the flag
    vld[0] = 1'b1; opc[0] = 6'd9;
    tick();
    check("ill_flag",   32'(a_oi), 32'h1);
    check("ill_onehot", 32'(a_oh), 32'h0);
    check("ill_valid",  32'(a_ov), 32'h1);
    check("ill_done",   32'(a_dn), 32'h0);
    opc[0] = 6'd3;
    tick();
    check("ill_clear",   32'(a_oi), 32'h0);
    check("or_onehot",   32'(a_oh), 32'h08);
    vld[0] = 1'b0;
    tick();

    // Div aborted by reset at T+10, with a valid also offered in the reset cycle
    vld[0] = 1'b1; opc[0] = 6'd7;
    tick();
    vld[0] = 1'b0;
    repeat (9) tick();
    rst[0] = 1'b1; vld[0] = 1'b1; opc[0] = 6'd0;
    tick();
    check("abort_busy",   32'(a_bsy), 32'h0);
    check("abort_onehot", 32'(a_oh),  32'h0);
    check("abort_valid",  32'(a_ov),  32'h0);
    rst[0] = 1'b0; vld[0] = 1'b0;
    #1;
    check("abort_ready", 32'(a_rdy), 32'h1);
    dn_count = 0;
    repeat (25) begin
      tick();
      if (a_dn) dn_count++;
    end
    check("abort_no_done", 32'(dn_count), 32'h0);

    // Small-parameter instance: 2-cycle mul, 3-cycle div, 16-op map boundary
    vld[1] = 1'b1; opc[1] = 6'd6;
    tick();
    check("b_mul_done",   32'(b_dn),  32'h1);
    check("b_mul_valid",  32'(b_ov),  32'h1);
    check("b_mul_busy",   32'(b_bsy), 32'h0);
    check("b_mul_onehot", 32'(b_oh),  32'h0040);
    opc[1] = 6'd15;
    tick();
    check("b_op15_onehot",  32'(b_oh), 32'h8000);
    check("b_op15_illegal", 32'(b_oi), 32'h0);
    opc[1] = 6'd16;
    tick();
    check("b_op16_illegal", 32'(b_oi), 32'h1);
    check("b_op16_onehot",  32'(b_oh), 32'h0);
    opc[1] = 6'd7;
    tick();
    check("b_div_busy",  32'(b_bsy), 32'h1);
    check("b_div_valid", 32'(b_ov),  32'h0);
    vld[1] = 1'b0;
    tick();
    check("b_div_done",  32'(b_dn),  32'h1);
    check("b_div_busy_clear", 32'(b_bsy), 32'h0);
    repeat (3) tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
